// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction fetch unit and the main
// control decoder.
//   - fetch_state_e      : fetch sequencer FSM states
//   - OPC_MSB / OPC_LSB  : location of the opcode field in an instruction word
//   - RESET_PC_DEFAULT   : default program counter after reset
//   - OP_*               : primary opcode encodings seen by the decoder
//   - opcode_of()        : extracts the opcode field from an instruction word
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// ifetch_pc_reg: program counter register with its next-PC selection.
// Priority: redirect load > sequential advance (+PC_STEP, wraps) > hold.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (pc -> RESET_PC)
//   load_redirect  : load redirect_pc this cycle
//   redirect_pc    : redirect target (already aligned by the caller)
//   advance        : step to the next sequential address
//   pc             : current program counter
module ifetch_pc_reg
  import mips_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_STEP_W = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Next-PC mux; the add wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load_redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_q + PC_STEP_W;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch sequencer feeding decode.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (adds fetch_fault output and
// parks the fetcher on a misaligned redirect; without it the low two target
// bits are cleared on load).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        : request channel (addr = current pc)
//   imem_resp_valid/data             : response strobe and instruction word
//   stall                            : decode cannot take the held instruction
//   redirect_valid/redirect_pc       : taken branch/jump pulse and target
//   instr_valid/instr/opcode/instr_pc: held instruction presented to decode
//   fetch_fault (macro only)         : sticky misaligned-redirect flag
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  fetch_state_e      state_d, state_q;
  logic              kill_d, kill_q;
  logic [31:0]       instr_d, instr_q;
  logic [ADDR_W-1:0] instr_pc_d, instr_pc_q;
  logic              instr_valid_d, instr_valid_q;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              pc_load;
  logic              pc_advance;
  logic              park;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_d, fault_q;

  assign redirect_tgt = redirect_pc;
  // Park on a fresh misaligned redirect, and keep parking once faulted.
  assign park    = fault_q | (redirect_valid & (|redirect_pc[1:0]));
  assign fault_d = park;
`else
  // Targets are word aligned by construction when the check is disabled.
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
  assign park         = 1'b0;
`endif

  ifetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_redirect (pc_load),
    .redirect_pc   (redirect_tgt),
    .advance       (pc_advance),
    .pc            (pc)
  );

  // Next-state and datapath control; redirect overrides normal sequencing.
  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_load       = 1'b0;
    pc_advance    = 1'b0;

    if (park) begin
      state_d       = ST_IDLE;
      kill_d        = 1'b0;
      instr_valid_d = 1'b0;
      pc_load       = redirect_valid;
    end else if (redirect_valid) begin
      pc_load       = 1'b1;
      instr_valid_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            // Old-address request already accepted: its response must be dropped.
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid && kill_q) begin
            // pc already holds the redirect target.
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else if (imem_resp_valid) begin
            instr_d       = imem_resp_data;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            pc_advance    = 1'b1;
            state_d       = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_valid_d = 1'b0;
            state_d       = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and instruction holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      kill_q        <= 1'b0;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`endif

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign opcode         = opcode_of(instr_q);
  assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0000_0000;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  ifetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .opcode          (opcode),
    .instr_pc        (instr_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, then check its address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, imem_req_addr, exp_addr);
  endtask

  task automatic accept();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    logic [31:0] e_instr;
    chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      e_instr = e.instr;
      chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd1);
      chk({tag, "_instr"}, instr, e_instr);
      chk({tag, "_opcode"}, 32'(opcode), 32'(e_instr[31:26]));
      chk({tag, "_instr_pc"}, instr_pc, e.pc);
    end
  endtask

  // Complete one fetch: request, accept, respond after lat idle cycles.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input logic stall_after);
    exp_t e;
    wait_req(tag, addr);
    accept();
    repeat (lat) @(negedge clk);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    stall           = stall_after;
    e.instr = data;
    e.pc    = addr;
    sb_q.push_back(e);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    check_out(tag);
  endtask

  initial begin
    logic [31:0] held_instr;
    logic [31:0] held_pc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_instr_pc", instr_pc, 32'h0000_0000);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b1;

    // First fetch at 0x0, LW opcode
    do_fetch("f0", 32'h0000_0000, 32'h8C08_0004, 1, 1'b0);
    chk("f0_opcode_lw", 32'(opcode), 32'(6'b100011));

    // Second fetch at 0x4 held under stall; stray response must be ignored
    do_fetch("f4", 32'h0000_0004, 32'h2009_0007, 1, 1'b1);
    held_instr = instr;
    held_pc    = instr_pc;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hFFFF_FFFF;
      end else begin
        imem_resp_valid = 1'b0;
      end
      @(negedge clk);
      chk("stall_instr", instr, held_instr);
      chk("stall_instr_pc", instr_pc, held_pc);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    end
    imem_resp_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_valid", 32'(instr_valid), 32'd0);
    wait_req("after_stall", 32'h0000_0008);

    // Redirect one cycle after 0x8 is accepted: response discarded
    accept();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("kill_wait_req_valid", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    chk("kill_instr_valid", 32'(instr_valid), 32'd0);
    chk("kill_instr_kept", instr, 32'h2009_0007);
    do_fetch("f100", 32'h0000_0100, 32'h2008_0005, 2, 1'b0);

    // Redirect coincident with the response in WAIT
    wait_req("f104", 32'h0000_0104);
    accept();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0000_0200;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    chk("coinc_instr_valid", 32'(instr_valid), 32'd0);
    wait_req("coinc", 32'h0000_0200);

    // Redirect while REQ is accepted, then again in WAIT: latest target wins
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_pc    = 32'hFFFF_FFFC;
    chk("req_acc_kill_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hAAAA_5555;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    chk("double_kill_valid", 32'(instr_valid), 32'd0);

    // Fetch at the top of the address space, then wrap
    do_fetch("ftop", 32'hFFFF_FFFC, 32'h0000_0020, 0, 1'b0);
    wait_req("wrap", 32'h0000_0000);

    // Misaligned redirect while a request is pending
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (4) @(negedge clk);
    chk("fault_sticky", 32'(fetch_fault), 32'd1);
    chk("fault_parked_req", 32'(imem_req_valid), 32'd0);
    chk("fault_instr_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("fault_cleared", 32'(fetch_fault), 32'd0);
    wait_req("post_fault", 32'h0000_0000);
`else
    wait_req("misalign", 32'h0000_0100);
    chk("misalign_instr_valid", 32'(instr_valid), 32'd0);
`endif

    // Reset mid-transaction, then a late response that must be ignored
    accept();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr, 32'h0000_0000);
    chk("midrst_instr_pc", instr_pc, 32'h0000_0000);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h8C00_0000;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    chk("late_resp_instr_valid", 32'(instr_valid), 32'd0);
    chk("late_resp_instr", instr, 32'h0000_0000);
    wait_req("post_rst", 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
